// File: rtl/flow_ctrl_sequencer_pkg.sv
// Shared types and constants for the CALL/RET/RTI/INT stack sequencer.
// Word widths, the interrupt vector and the sequencer state encoding.
package flow_ctrl_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 2 * DATA_W;
  localparam int FLAG_W = 4;

  localparam logic [PC_W-1:0] INT_VEC = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE,
    C_HI,
    C_LO,
    R_LO,
    R_HI,
    I_HI,
    I_LO,
    I_FL,
    T_FL,
    T_LO,
    T_HI
  } seq_state_t;

  function automatic logic [DATA_W-1:0] flag_word(
    input logic [FLAG_W-1:0] f
  );
    return {{(DATA_W-FLAG_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/flow_ctrl_sequencer_if.sv
// Stack memory beat bus plus the SP unit pulses.
// master = sequencer side, slave = memory/SP side.
interface flow_ctrl_sequencer_if;
  import flow_ctrl_sequencer_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              sp_push;
  logic              sp_pop;

  modport master (
    output mem_req,
    output mem_we,
    output mem_wdata,
    output sp_push,
    output sp_pop,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_wdata,
    input  sp_push,
    input  sp_pop,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/flow_ctrl_sequencer_beat.sv
// One stack beat: holds req/we/wdata from start until mem_ready,
// and emits the matching SP pulse in the completing cycle.
module stack_beat_ctrl
  import flow_ctrl_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              beat_done,
  output logic [DATA_W-1:0] rdata,
  flow_ctrl_sequencer_if.master mem
);

  logic              active;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  // start on the completing cycle chains the next beat one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start) begin
      active  <= 1'b1;
      we_q    <= we;
      wdata_q <= wdata;
    end else if (beat_done) begin
      active  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  assign beat_done     = active & mem.mem_ready & ~rst;
  assign mem.mem_req   = active;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.sp_push   = beat_done & we_q;
  assign mem.sp_pop    = beat_done & ~we_q;
  assign rdata         = mem.mem_rdata;

endmodule

// File: rtl/flow_ctrl_sequencer.sv
// Multi-cycle CALL/RET/RTI/interrupt sequencer between decode and
// the stack memory; stalls the front end while stack beats run.
module flow_ctrl_sequencer
  import flow_ctrl_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              call,
  input  logic              ret,
  input  logic              rti,
  input  logic [PC_W-1:0]   call_target,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              intr,
  input  logic [PC_W-1:0]   int_pc,
  input  logic [FLAG_W-1:0] flags_in,
  flow_ctrl_sequencer_if.master mem,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              done
);

  seq_state_t state;
  seq_state_t nxt;

  logic              int_pend;
  logic [DATA_W-1:0] lo_q;
  logic [PC_W-1:0]   tgt_q;
  logic [FLAG_W-1:0] flags_q;

  logic              start;
  logic              bwe;
  logic [DATA_W-1:0] bwdata;
  logic              beat_done;
  logic [DATA_W-1:0] rdata;

  logic acc;
  logic acc_call;
  logic acc_int;
  logic cap_lo;
  logic cap_fl;

  stack_beat_ctrl u_beat (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (bwe),
    .wdata     (bwdata),
    .beat_done (beat_done),
    .rdata     (rdata),
    .mem       (mem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      int_pend <= 1'b0;
      lo_q     <= '0;
      tgt_q    <= '0;
      flags_q  <= '0;
    end else begin
      state    <= nxt;
      int_pend <= (int_pend & ~acc_int) | intr;
      if (acc) begin
        tgt_q   <= call_target;
        lo_q    <= acc_call ? ret_pc[DATA_W-1:0]
                            : int_pc[DATA_W-1:0];
        flags_q <= flags_in;
      end
      if (cap_lo) lo_q    <= rdata;
      if (cap_fl) flags_q <= rdata[FLAG_W-1:0];
    end
  end

  always_comb begin
    nxt         = state;
    start       = 1'b0;
    bwe         = 1'b0;
    bwdata      = '0;
    stall       = (state != IDLE);
    pc_load     = 1'b0;
    pc_value    = '0;
    flags_load  = 1'b0;
    flags_value = '0;
    done        = 1'b0;
    acc         = 1'b0;
    acc_call    = 1'b0;
    acc_int     = 1'b0;
    cap_lo      = 1'b0;
    cap_fl      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (call) begin
            acc_call = 1'b1;
            bwe      = 1'b1;
            bwdata   = ret_pc[PC_W-1:DATA_W];
            nxt      = C_HI;
          end else if (ret) begin
            nxt = R_LO;
          end else if (rti) begin
            nxt = T_FL;
          end else if (int_pend) begin
            acc_int = 1'b1;
            bwe     = 1'b1;
            bwdata  = int_pc[PC_W-1:DATA_W];
            nxt     = I_HI;
          end
          acc   = (nxt != IDLE);
          start = acc;
          stall = acc;
        end
      end
      C_HI: if (beat_done) begin
        start  = 1'b1;
        bwe    = 1'b1;
        bwdata = lo_q;
        nxt    = C_LO;
      end
      C_LO: if (beat_done) begin
        pc_load  = 1'b1;
        pc_value = tgt_q;
        done     = 1'b1;
        nxt      = IDLE;
      end
      R_LO: if (beat_done) begin
        cap_lo = 1'b1;
        start  = 1'b1;
        nxt    = R_HI;
      end
      R_HI: if (beat_done) begin
        pc_load  = 1'b1;
        pc_value = {rdata, lo_q};
        done     = 1'b1;
        nxt      = IDLE;
      end
      I_HI: if (beat_done) begin
        start  = 1'b1;
        bwe    = 1'b1;
        bwdata = lo_q;
        nxt    = I_LO;
      end
      I_LO: if (beat_done) begin
        start  = 1'b1;
        bwe    = 1'b1;
        bwdata = flag_word(flags_q);
        nxt    = I_FL;
      end
      I_FL: if (beat_done) begin
        pc_load  = 1'b1;
        pc_value = INT_VEC;
        done     = 1'b1;
        nxt      = IDLE;
      end
      T_FL: if (beat_done) begin
        cap_fl = 1'b1;
        start  = 1'b1;
        nxt    = T_LO;
      end
      T_LO: if (beat_done) begin
        cap_lo = 1'b1;
        start  = 1'b1;
        nxt    = T_HI;
      end
      T_HI: if (beat_done) begin
        pc_load     = 1'b1;
        pc_value    = {rdata, lo_q};
        flags_load  = 1'b1;
        flags_value = flags_q;
        done        = 1'b1;
        nxt         = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flow_ctrl_sequencer.sv
// Scoreboard bench: a stack-level model predicts beats and PC reloads,
// a monitor checks every completed beat and every pc_load.
module tb_flow_ctrl_sequencer;
  import flow_ctrl_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        call, ret, rti, intr;
  logic [31:0] call_target, ret_pc, int_pc;
  logic [3:0]  flags_in;
  logic        stall, pc_load, flags_load, done;
  logic [31:0] pc_value;
  logic [3:0]  flags_value;

  flow_ctrl_sequencer_if mem_if();

  flow_ctrl_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .call        (call),
    .ret         (ret),
    .rti         (rti),
    .call_target (call_target),
    .ret_pc      (ret_pc),
    .intr        (intr),
    .int_pc      (int_pc),
    .flags_in    (flags_in),
    .mem         (mem_if),
    .stall       (stall),
    .pc_load     (pc_load),
    .pc_value    (pc_value),
    .flags_load  (flags_load),
    .flags_value (flags_value),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic [3:0]  f;
  } end_t;

  beat_t       exp_beats[$];
  end_t        exp_ends[$];
  logic [15:0] ref_stack[$];
  logic [15:0] mem_stack[$];

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;
  bit waited = 0;
  bit acc_stall;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // memory/SP side responder
  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: mem_if.mem_ready = 1'b1;
        1: begin
          if (mem_if.mem_req && !waited) begin
            mem_if.mem_ready = 1'b0;
            waited = 1'b1;
          end else begin
            mem_if.mem_ready = 1'b1;
            waited = 1'b0;
          end
        end
        2: mem_if.mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_if.mem_ready = 1'b0;
      endcase
      mem_if.mem_rdata = (mem_stack.size() > 0) ? mem_stack[$] : 16'hdead;
    end
  end

  beat_t mb;
  end_t  me;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_if.mem_req && mem_if.mem_ready) begin
        if (exp_beats.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected act=1 exp=0 t=%0t", $time);
        end else begin
          mb = exp_beats.pop_front();
          chk("beat_we", mem_if.mem_we, mb.we);
          if (mb.we) chk("beat_wdata", mem_if.mem_wdata, mb.data);
          chk("sp_push", mem_if.sp_push, mb.we);
          chk("sp_pop", mem_if.sp_pop, !mb.we);
          chk("stall_in_beat", stall, 1);
        end
        if (mem_if.mem_we) mem_stack.push_back(mem_if.mem_wdata);
        else if (mem_stack.size() > 0) void'(mem_stack.pop_back());
      end else begin
        chk("sp_idle", {mem_if.sp_push, mem_if.sp_pop}, 0);
      end
      chk("done_vs_pcload", done, pc_load);
      if (pc_load) begin
        if (exp_ends.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pcload_unexpected act=1 exp=0 t=%0t", $time);
        end else begin
          me = exp_ends.pop_front();
          chk("pc_value", pc_value, me.pc);
          chk("flags_load", flags_load, me.fl);
          if (me.fl) chk("flags_value", flags_value, me.f);
        end
      end else begin
        chk("flags_load_idle", flags_load, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic we, input logic [15:0] d);
    beat_t b;
    b.we = we;
    b.data = d;
    exp_beats.push_back(b);
  endtask

  task automatic push_end(input logic [31:0] pc,
                          input logic fl, input logic [3:0] f);
    end_t e;
    e.pc = pc;
    e.fl = fl;
    e.f = f;
    exp_ends.push_back(e);
  endtask

  task automatic prep_call(input logic [31:0] rp, input logic [31:0] tg);
    push_beat(1'b1, rp[31:16]);
    push_beat(1'b1, rp[15:0]);
    push_end(tg, 1'b0, 4'h0);
    ref_stack.push_back(rp[31:16]);
    ref_stack.push_back(rp[15:0]);
    ret_pc = rp;
    call_target = tg;
    call = 1'b1;
  endtask

  task automatic prep_ret();
    logic [15:0] lo, hi;
    lo = ref_stack.pop_back();
    hi = ref_stack.pop_back();
    push_beat(1'b0, 16'h0);
    push_beat(1'b0, 16'h0);
    push_end({hi, lo}, 1'b0, 4'h0);
    ret = 1'b1;
  endtask

  task automatic prep_rti();
    logic [15:0] f, lo, hi;
    f  = ref_stack.pop_back();
    lo = ref_stack.pop_back();
    hi = ref_stack.pop_back();
    push_beat(1'b0, 16'h0);
    push_beat(1'b0, 16'h0);
    push_beat(1'b0, 16'h0);
    push_end({hi, lo}, 1'b1, f[3:0]);
    rti = 1'b1;
  endtask

  task automatic prep_int(input logic [31:0] ip, input logic [3:0] fl);
    push_beat(1'b1, ip[31:16]);
    push_beat(1'b1, ip[15:0]);
    push_beat(1'b1, {12'h000, fl});
    push_end(INT_VEC, 1'b0, 4'h0);
    ref_stack.push_back(ip[31:16]);
    ref_stack.push_back(ip[15:0]);
    ref_stack.push_back({12'h000, fl});
    int_pc = ip;
    flags_in = fl;
    intr = 1'b1;
  endtask

  task automatic fire();
    @(negedge clk);
    acc_stall = stall;
    @(posedge clk);
    #1;
    call = 1'b0;
    ret  = 1'b0;
    rti  = 1'b0;
    intr = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (stall) n++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout act=nodone exp=done", nm);
    end
    tick();
  endtask

  int n;
  int op;
  bit inj;

  initial begin
    rst = 1'b1;
    call = 0; ret = 0; rti = 0; intr = 0;
    call_target = 0; ret_pc = 0; int_pc = 0; flags_in = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      ref_stack.push_back(w);
      mem_stack.push_back(w);
    end
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", {stall, mem_if.mem_req, mem_if.mem_we,
        mem_if.sp_push, mem_if.sp_pop, pc_load, flags_load, done}, 0);
    chk("reset_wdata", mem_if.mem_wdata, 0);
    tick();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_stall", stall, 0);
    end
    tick();

    // 1: CALL, ready tied high
    ready_mode = 0;
    prep_call(32'h0001_0024, 32'h0000_0100);
    fire();
    wait_done("call", n);
    chk("call_stall_cycles", n + int'(acc_stall), 3);

    // 2: RET, one wait state per beat
    ready_mode = 1;
    prep_ret();
    fire();
    wait_done("ret", n);
    chk("ret_stall_cycles", n + int'(acc_stall), 5);
    ready_mode = 0;
    tick();

    // 3: interrupt pulse in IDLE
    prep_int(32'h0000_0042, 4'b0101);
    fire();
    wait_done("int", n);
    chk("int_stall_cycles", n + int'(acc_stall), 4);
    repeat (3) begin
      @(negedge clk);
      chk("int_pend_cleared", stall, 0);
    end
    tick();

    // 4: RTI
    prep_rti();
    fire();
    wait_done("rti", n);
    chk("rti_stall_cycles", n + int'(acc_stall), 4);

    // 5: call and intr together
    prep_call(32'h1234_5678, 32'h0000_0200);
    prep_int(32'h00ab_cdef, 4'b1010);
    fire();
    wait_done("prio_call", n);
    #1;
    @(negedge clk);
    chk("int_accept_after_done", {stall, mem_if.mem_req}, 2'b10);
    wait_done("prio_int", n);
    tick();

    // 6: reset while CALL beat 2 waits
    prep_call(32'h0bad_f00d, 32'h0000_0300);
    fire();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    ready_mode = 3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_beats.delete();
    exp_ends.delete();
    void'(ref_stack.pop_back());
    @(negedge clk);
    chk("rst_mid_outs", {stall, mem_if.mem_req, mem_if.mem_we,
        mem_if.sp_push, mem_if.sp_pop, pc_load, flags_load, done}, 0);
    chk("rst_mid_pc", pc_value, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_clears_int_pend", {stall, mem_if.mem_req}, 0);
    end
    tick();
    ready_mode = 0;
    prep_call(32'h0000_1111, 32'h0000_0400);
    fire();
    wait_done("call_after_rst", n);
    chk("call_after_rst_stall", n + int'(acc_stall), 3);

    // randomized mix with random wait states
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      if (op == 1 && ref_stack.size() < 2) op = 0;
      if (op == 3 && ref_stack.size() < 3) op = 0;
      if (ref_stack.size() > 60 && (op == 0 || op == 2)) op = 1;
      inj = (op != 2) && ($urandom_range(0, 3) == 0);
      case (op)
        0: prep_call($urandom, $urandom);
        1: prep_ret();
        2: prep_int($urandom, 4'($urandom));
        default: prep_rti();
      endcase
      fire();
      if (inj) begin
        prep_int($urandom, 4'($urandom));
        tick();
        intr = 1'b0;
      end
      wait_done("rand", n);
      if (inj) wait_done("rand_int", n);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("exp_beats_left", exp_beats.size(), 0);
    chk("exp_ends_left", exp_ends.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
